reaction_timer_ctrl: RTL and testbench

- Control front end of the Lab2 reaction timer; sits directly upstream of hex_counter / hex_to_bcd_converter.
- Turns raw KEY presses into a game state machine, generates a 1 ms tick from the 50 MHz clock, inserts a pseudo-random wait, and produces the elapsed-millisecond count.
- elapsed_ms feeds the BCD converter and seven-segment path; best_ms drives the second display bank.

---
 rtl/reaction_timer_ctrl_pkg.sv | 23 ++
 rtl/reaction_timer_ctrl_lfsr16.sv | 34 +++
 rtl/reaction_timer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared definitions for the reaction timer control block.
//   state_e      : FSM state encoding, visible on the top-level state port.
//   LfsrSeed     : LFSR value loaded on reset.
//   LfsrTaps     : feedback tap mask (taps 16,14,13,11 -> bits 15,13,12,10).
//   lfsr_next()  : one step of the Fibonacci LFSR.
package reaction_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StRun   = 3'd2,
    StDone  = 3'd3,
    StEarly = 3'd4
  } state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LfsrTaps)};
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR used to randomise the wait before the GO lamp.
// Advances every clock while Reset_n is high.
//   Clock   : system clock
//   Reset_n : asynchronous active-low reset, loads LfsrSeed
//   q       : current LFSR value
module lfsr16
  import reaction_timer_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset_n,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
    // All-zero is a lockup state; unreachable from the seed, but recover anyway.
    if (lfsr_d == 16'h0000) begin
      lfsr_d = LfsrSeed;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer control front end.
// Synchronises the raw keys into one-cycle press pulses, derives a 1 ms tick,
// runs the game FSM with a pseudo-random arming delay and tracks elapsed/best
// reaction times in milliseconds.
//   Clock        : system clock
//   Reset_n      : asynchronous active-low reset
//   start_key_n  : raw start key, active-low, asynchronous
//   stop_key_n   : raw stop key, active-low, asynchronous
//   clear_key_n  : raw clear key, active-low, clears best score
//   elapsed_ms   : current / frozen reaction time
//   best_ms      : lowest completed reaction time, all-ones when none
//   led_go       : high while in RUN
//   too_early    : high while in EARLY
//   state        : current FSM state encoding
module reaction_timer_ctrl
  import reaction_timer_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 12,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             start_key_n,
  input  logic             stop_key_n,
  input  logic             clear_key_n,
  output logic [CNT_W-1:0] elapsed_ms,
  output logic [CNT_W-1:0] best_ms,
  output logic             led_go,
  output logic             too_early,
  output logic [2:0]       state
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Wide enough for MIN_DELAY_MS + (2**RAND_BITS - 1).
  localparam int unsigned DelayW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));

  // Key index within the synchroniser vectors.
  localparam int unsigned KStart = 0;
  localparam int unsigned KStop  = 1;
  localparam int unsigned KClear = 2;

  logic [2:0]        sync1_q, sync2_q, prev_q;
  logic [2:0]        press;
  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick;
  logic              presc_restart;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  elapsed_q, elapsed_d;
  logic [CNT_W-1:0]  best_q, best_d;
  logic [DelayW-1:0] delay_q, delay_d;
  logic [DelayW-1:0] delay_load;
  logic              led_go_q, too_early_q;
  logic [15:0]       lfsr;
  logic              unused_lfsr;

  lfsr16 u_lfsr16 (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .q       (lfsr)
  );

  // Only the low RAND_BITS feed the delay.
  assign unused_lfsr = ^lfsr;

  // Falling edge of the synchronised key; release edges produce nothing.
  assign press = prev_q & ~sync2_q;

  assign tick = (presc_q == PrescW'(TICK_DIV - 1));

  assign delay_load = DelayW'(MIN_DELAY_MS) + DelayW'(lfsr[RAND_BITS-1:0]);

  always_comb begin
    presc_d = presc_q + PrescW'(1);
    if (presc_restart || tick) begin
      presc_d = '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    elapsed_d     = elapsed_q;
    best_d        = best_q;
    delay_d       = delay_q;
    presc_restart = 1'b0;

    if (press[KClear]) begin
      state_d   = StIdle;
      elapsed_d = '0;
      best_d    = '1;
    end else begin
      unique case (state_q)
        StIdle, StDone, StEarly: begin
          if (press[KStart]) begin
            state_d       = StArm;
            delay_d       = delay_load;
            presc_restart = 1'b1;
          end
        end
        StArm: begin
          if (press[KStop]) begin
            state_d = StEarly;
          end else if (tick) begin
            if (delay_q == DelayW'(1)) begin
              state_d       = StRun;
              elapsed_d     = '0;
              presc_restart = 1'b1;
            end else begin
              delay_d = delay_q - DelayW'(1);
            end
          end
        end
        StRun: begin
          if (press[KStop]) begin
            // elapsed_q is the frozen result; fold it into best on this edge.
            state_d = StDone;
            if (elapsed_q < best_q) begin
              best_d = elapsed_q;
            end
          end else if (tick && (elapsed_q != '1)) begin
            elapsed_d = elapsed_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      prev_q      <= '1;
      presc_q     <= '0;
      state_q     <= StIdle;
      elapsed_q   <= '0;
      best_q      <= '1;
      delay_q     <= '0;
      led_go_q    <= 1'b0;
      too_early_q <= 1'b0;
    end else begin
      sync1_q     <= {clear_key_n, stop_key_n, start_key_n};
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      presc_q     <= presc_d;
      state_q     <= state_d;
      elapsed_q   <= elapsed_d;
      best_q      <= best_d;
      delay_q     <= delay_d;
      led_go_q    <= (state_d == StRun);
      too_early_q <= (state_d == StEarly);
    end
  end

  assign elapsed_ms = elapsed_q;
  assign best_ms    = best_q;
  assign led_go     = led_go_q;
  assign too_early  = too_early_q;
  assign state      = state_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
module tb_reaction_timer_ctrl;

  localparam int TickDiv  = 4;
  localparam int MinDelay = 2;
  localparam int RandBits = 2;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start_key_n = 1'b1, stop_key_n = 1'b1, clear_key_n = 1'b1;
  logic [31:0] elapsed_ms, best_ms;
  logic        led_go, too_early;
  logic [2:0]  state;

  // Narrow-counter instance for the saturation scenario.
  logic        s2_start_n = 1'b1;
  logic [3:0]  elapsed2, best2;
  logic        led_go2, too_early2;
  logic [2:0]  state2;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [31:0] best_model = 32'hFFFF_FFFF;

  always #5 Clock = ~Clock;

  // Clock edges seen since reset release; the LFSR advances on exactly these.
  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  reaction_timer_ctrl #(
    .TICK_DIV(TickDiv), .MIN_DELAY_MS(MinDelay), .RAND_BITS(RandBits), .CNT_W(32)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .start_key_n(start_key_n), .stop_key_n(stop_key_n),
    .clear_key_n(clear_key_n), .elapsed_ms(elapsed_ms), .best_ms(best_ms), .led_go(led_go),
    .too_early(too_early), .state(state)
  );

  reaction_timer_ctrl #(
    .TICK_DIV(TickDiv), .MIN_DELAY_MS(MinDelay), .RAND_BITS(RandBits), .CNT_W(4)
  ) dut2 (
    .Clock(Clock), .Reset_n(Reset_n), .start_key_n(s2_start_n), .stop_key_n(1'b1),
    .clear_key_n(1'b1), .elapsed_ms(elapsed2), .best_ms(best2), .led_go(led_go2),
    .too_early(too_early2), .state(state2)
  );

  // Reference LFSR: taps 16,14,13,11, shifting towards the MSB.
  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v = 16'hACE1;
    for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mask bit0 start, bit1 stop, bit2 clear. Returns on the negedge after the
  // acting edge; mid_state is the state one edge before that.
  task automatic press(input logic [2:0] mask, output logic [2:0] mid_state);
    start_key_n = ~mask[0];
    stop_key_n  = ~mask[1];
    clear_key_n = ~mask[2];
    @(negedge Clock);
    @(negedge Clock);
    mid_state = state;
    @(negedge Clock);
    start_key_n = 1'b1;
    stop_key_n  = 1'b1;
    clear_key_n = 1'b1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check(tag, {29'd0, state}, {29'd0, s});
  endtask

  // Start from IDLE/DONE/EARLY, play a round, stop after wait_cycles in RUN.
  task automatic do_round(input string tag, input int wait_cycles, input logic [2:0] stop_mask);
    int ca, ce, cd, dly, exp_el;
    logic [2:0] mid, prior;
    repeat ($urandom_range(0, 6)) @(negedge Clock);
    prior = state;
    press(3'b001, mid);
    check({tag, "_mid"}, {29'd0, mid}, {29'd0, prior});
    check({tag, "_arm"}, {29'd0, state}, 32'd1);
    ca  = cyc;
    dly = MinDelay + int'(lfsr_after(ca - 1) & 16'h3);
    wait_state({tag, "_run"}, 3'd2, 40);
    ce = cyc;
    check({tag, "_armlen"}, ce - ca, 4 * dly);
    check({tag, "_go"}, {31'd0, led_go}, 32'd1);
    repeat (wait_cycles) @(negedge Clock);
    press(stop_mask, mid);
    cd = cyc;
    exp_el = (cd - ce - 1) / TickDiv;
    if (exp_el < best_model) best_model = exp_el;
    check({tag, "_done"}, {29'd0, state}, 32'd3);
    check({tag, "_elapsed"}, elapsed_ms, exp_el);
    check({tag, "_best"}, best_ms, best_model);
    check({tag, "_go_off"}, {31'd0, led_go}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] mid;
    int hi;

    #23;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_elapsed", elapsed_ms, 32'd0);
    check("rst_best", best_ms, 32'hFFFF_FFFF);
    check("rst_go", {31'd0, led_go}, 32'd0);
    check("rst_early", {31'd0, too_early}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat ($urandom_range(1, 9)) @(negedge Clock);

    // Directed rounds: 40, 24 and 60 cycles of RUN before stop.
    do_round("r40", 39, 3'b010);
    check("r40_ten", elapsed_ms, 32'd10);
    do_round("r24", 23, 3'b010);
    check("r24_six", best_ms, 32'd6);
    do_round("r60", 59, 3'b010);
    check("r60_keep", best_ms, 32'd6);

    // Clear in DONE.
    press(3'b100, mid);
    best_model = 32'hFFFF_FFFF;
    check("clr_state", {29'd0, state}, 32'd0);
    check("clr_elapsed", elapsed_ms, 32'd0);
    check("clr_best", best_ms, 32'hFFFF_FFFF);

    // Early stop.
    press(3'b001, mid);
    check("e_arm", {29'd0, state}, 32'd1);
    press(3'b010, mid);
    check("e_state", {29'd0, state}, 32'd4);
    check("e_flag", {31'd0, too_early}, 32'd1);
    hi = 0;
    repeat (30) begin
      @(negedge Clock);
      if (led_go !== 1'b0) hi++;
    end
    check("e_no_go", hi, 0);
    check("e_hold", {29'd0, state}, 32'd4);

    // From EARLY back to ARM, then start+stop together in RUN: stop wins.
    do_round("both_run", 10, 3'b011);

    // Start+stop together in IDLE: start wins.
    press(3'b100, mid);
    best_model = 32'hFFFF_FFFF;
    press(3'b011, mid);
    check("both_idle", {29'd0, state}, 32'd1);
    check("both_idle_flag", {31'd0, too_early}, 32'd0);
    wait_state("both_idle_run", 3'd2, 40);
    press(3'b010, mid);
    check("both_idle_done", {29'd0, state}, 32'd3);
    if (elapsed_ms < best_model) best_model = elapsed_ms;

    // Randomised rounds.
    for (int i = 0; i < 4; i++) do_round("rnd", $urandom_range(0, 45), 3'b010);

    // Asynchronous reset in the middle of RUN.
    press(3'b001, mid);
    wait_state("ar_run", 3'd2, 40);
    repeat (5) @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    check("ar_state", {29'd0, state}, 32'd0);
    check("ar_elapsed", elapsed_ms, 32'd0);
    check("ar_best", best_ms, 32'hFFFF_FFFF);
    check("ar_go", {31'd0, led_go}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    best_model = 32'hFFFF_FFFF;

    // Saturation on the 4-bit instance.
    @(negedge Clock);
    s2_start_n = 1'b0;
    repeat (3) @(negedge Clock);
    s2_start_n = 1'b1;
    check("sat_arm", {29'd0, state2}, 32'd1);
    hi = 0;
    while (state2 !== 3'd2 && hi < 40) begin
      @(negedge Clock);
      hi++;
    end
    check("sat_run", {29'd0, state2}, 32'd2);
    repeat (40) @(negedge Clock);
    check("sat_mid", {28'd0, elapsed2}, 32'd10);
    repeat (40) @(negedge Clock);
    check("sat_top", {28'd0, elapsed2}, 32'd15);
    check("sat_still_run", {29'd0, state2}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
